// File: rtl/bp_pkg.sv
// Shared types and helpers for the fetch-stage branch predictor: 2-bit counter
// encodings, the BTB entry layout and the saturating counter next-state rule.
package bp_pkg;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  // Tag width of the default 64-entry table (32 - INDEX_BITS - 2)
  localparam int BTB_TAG_BITS = 24;

  typedef struct packed {
    logic                    valid;
    logic [BTB_TAG_BITS-1:0] tag;
    logic [31:0]             target;
  } btb_entry_t;

  function automatic logic [1:0] sat_ctr_next(input logic [1:0] ctr, input logic taken);
    logic [1:0] nxt;
    nxt = ctr;
    if (taken) begin
      if (ctr != ST) nxt = ctr + 2'd1;
    end else begin
      if (ctr != SNT) nxt = ctr - 2'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/sat_counter2.sv
// 2-bit saturating direction counter next-state logic; one instance serves the
// single execute-stage update path rather than one per table entry.
module sat_counter2
  import bp_pkg::*;
(
  input  logic [1:0] ctr_q,
  input  logic       taken,
  output logic [1:0] ctr_d
);

  assign ctr_d = sat_ctr_next(ctr_q, taken);

endmodule

// File: rtl/branch_predictor_btb.sv
// Fetch-stage branch predictor: direct-mapped BTB plus 2-bit direction counters,
// trained from execute-stage resolution, with a saturating mispredict counter.
module branch_predictor_btb
  import bp_pkg::*;
#(
  parameter int         INDEX_BITS = 6,
  parameter int         TAG_BITS   = 24,
  parameter logic [1:0] CTR_INIT   = WT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_f,
  output logic        predicted_taken_f,
  output logic [31:0] predicted_target_f,
  input  logic        update_en_e,
  input  logic [31:0] update_pc_e,
  input  logic        update_taken_e,
  input  logic [31:0] update_target_e,
  input  logic        mispredict_e,
  input  logic        clear_stats,
  output logic [31:0] mispredict_count
);

  localparam int ENTRIES = 1 << INDEX_BITS;

  // Flop arrays rather than SRAM so the whole table clears on async reset
  btb_entry_t btb_q [ENTRIES];
  logic [1:0] ctr_q [ENTRIES];

  logic [INDEX_BITS-1:0] idx;
  logic [INDEX_BITS-1:0] uidx;
  logic [TAG_BITS-1:0]   tag;
  logic [TAG_BITS-1:0]   utag;
  logic                  hit;
  logic                  uhit;
  logic [1:0]            ctr_upd;

  assign idx  = pc_f[INDEX_BITS+1:2];
  assign tag  = pc_f[31:INDEX_BITS+2];
  assign uidx = update_pc_e[INDEX_BITS+1:2];
  assign utag = update_pc_e[31:INDEX_BITS+2];

  assign hit  = btb_q[idx].valid && (btb_q[idx].tag == tag);
  assign uhit = btb_q[uidx].valid && (btb_q[uidx].tag == utag);

  // Lookup reads the registered table only, so a same-cycle update is not bypassed
  assign predicted_taken_f  = hit & ctr_q[idx][1];
  assign predicted_target_f = predicted_taken_f ? btb_q[idx].target : pc_f + 32'd4;

  sat_counter2 u_sat_counter2 (
    .ctr_q (ctr_q[uidx]),
    .taken (update_taken_e),
    .ctr_d (ctr_upd)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        btb_q[i] <= '0;
        ctr_q[i] <= WNT;
      end
    end else if (update_en_e) begin
      if (uhit) begin
        ctr_q[uidx] <= ctr_upd;
        if (update_taken_e) btb_q[uidx].target <= update_target_e;
      end else if (update_taken_e) begin
        // Allocation on a taken miss evicts whatever tag owned the slot
        btb_q[uidx].valid  <= 1'b1;
        btb_q[uidx].tag    <= utag;
        btb_q[uidx].target <= update_target_e;
        ctr_q[uidx]        <= CTR_INIT;
      end
    end
  end

  // Clear wins over a same-cycle increment; the count sticks at all-ones
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mispredict_count <= '0;
    end else if (clear_stats) begin
      mispredict_count <= '0;
    end else if (update_en_e && mispredict_e && (mispredict_count != 32'hFFFF_FFFF)) begin
      mispredict_count <= mispredict_count + 32'd1;
    end
  end

endmodule

// File: doc/branch_predictor_btb.md
Name: branch_predictor_btb

Overview:
Fetch-stage branch predictor. It combines a direct-mapped branch target buffer (BTB) with 2-bit saturating direction counters.
- Looks up the fetch PC every cycle and drives the prediction that travels down the pipe to execute as predicted_taken_e / predicted_target_e.
- Trains from the execute-stage resolution: branch PC, actual outcome, actual target and the mispredict flag.
- Keeps a saturating mispredict counter for performance monitoring.

Parameters:
INDEX_BITS, 6, log2 of BTB entries (64 entries)
TAG_BITS, 24, tag width; must equal 32-INDEX_BITS-2
CTR_INIT, 2'b10, counter value written on allocation (weakly taken)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
pc_f  input  32  current fetch PC
predicted_taken_f  output  1  prediction for pc_f
predicted_target_f  output  32  predicted next PC for pc_f
update_en_e  input  1  a conditional branch is resolving in execute this cycle (BranchE)
update_pc_e  input  32  PC of the resolving branch (PCE)
update_taken_e  input  1  actual branch outcome
update_target_e  input  32  actual taken target (PCE + Imm_Ext_E)
mispredict_e  input  1  execute-stage mispredict flag
clear_stats  input  1  synchronous clear of mispredict_count
mispredict_count  output  32  saturating count of mispredicted branches

Behaviour:
Lookup and prediction (combinational from pc_f):
- idx = pc_f[INDEX_BITS+1:2]; tag = pc_f[31:INDEX_BITS+2].
- hit = valid[idx] & (tag_mem[idx] == tag).
- predicted_taken_f = hit & ctr[idx][1].
- predicted_target_f = predicted_taken_f ? target_mem[idx] : pc_f + 32'd4. Addition wraps mod 2^32.
- No same-cycle bypass: a lookup in the cycle an update writes the same entry returns the pre-update contents.

Update (registered on the rising clk edge, only when update_en_e = 1). Use uidx/utag derived from update_pc_e.
- Entry hit, taken: ctr saturating increment (11 stays 11); target_mem <= update_target_e.
- Entry hit, not taken: ctr saturating decrement (00 stays 00); target unchanged.
- Entry miss, taken: allocate. valid <= 1, tag <= utag, target <= update_target_e, ctr <= CTR_INIT. This overwrites any other tag in the slot.
- Entry miss, not taken: no change (no allocation).
- update_en_e = 0: the table holds; mispredict_e is ignored.

Statistics:
- mispredict_count increments by 1 when update_en_e & mispredict_e, and saturates at 32'hFFFFFFFF.
- If clear_stats is asserted, the counter clears to 0 and this takes priority over an increment in the same cycle.

Reset:
- Asynchronous. All valid bits = 0, all counters = 2'b01, tag/target storage = 0, mispredict_count = 0.
- During and immediately after reset: predicted_taken_f = 0 and predicted_target_f = pc_f + 4.
- Reset asserted mid-update aborts the write; the entry ends up invalid.

Latency:
- Prediction is available in the same cycle as pc_f.
- An update becomes visible to lookups from the cycle after the update edge.

Decomposition:
- Shared package bp_pkg:
  - counter encodings SNT=2'b00, WNT=2'b01, WT=2'b10, ST=2'b11
  - typedef btb_entry_t {valid, tag, target}
  - function sat_ctr_next(ctr, taken)
- One natural sub-module: sat_counter2, the 2-bit saturating next-state logic, instantiated per update path rather than per entry.
- Storage is flop arrays in the top module (64 x 57 bits plus 64 x 2 bits), not SRAM. Flops are required by the asynchronous reset.

Test Plan:
1. Reset, then pc_f=32'h0000_0100 -> predicted_taken_f=0, predicted_target_f=32'h0000_0104, mispredict_count=0.
2. Update pc=32'h100, taken=1, target=32'h200, mispredict=1, then lookup pc_f=32'h100 next cycle -> taken=1, target=32'h200, mispredict_count=1.
3. Same entry, two not-taken updates (10->01->00), then lookup -> taken=0, target=32'h104. One taken update (00->01) -> still not taken.
4. Alias test: allocate pc=32'h100, then taken update at pc=32'h500 (same index, different tag) -> pc_f=32'h100 misses (target 32'h104); pc_f=32'h500 hits with the new target.
5. Same-cycle update and lookup of pc=32'h300, first allocation -> that cycle predicts not taken (no bypass); the next cycle predicts taken.
6. Force mispredict_count to 32'hFFFFFFFE, apply 3 mispredicts -> holds at 32'hFFFFFFFF. Then clear_stats together with a mispredict -> 0. Assert rst mid-run -> all entries invalid, count=0.
